// File: rtl/cm_arb_pkg.sv
// Shared cm_arb definitions: arbiter state encoding and index-width helpers.
package cm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } cm_arb_state_e;

  function automatic int unsigned cm_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Index fields are never narrower than one bit, even for a single requester.
  function automatic int unsigned cm_idx_w(input int unsigned n);
    return (cm_clog2(n) < 1) ? 1 : cm_clog2(n);
  endfunction

endpackage

// File: rtl/cm_arb_rr_sel.sv
// Combinational rotate-priority selector: first requester found ascending from
// last_idx+1 (wrapping) wins; the previous owner is therefore considered last.
module cm_arb_rr_sel
  import cm_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned IDX_W   = cm_idx_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [REQ_NUM-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 1; i <= REQ_NUM; i++) begin
      w_pos = IDX_W'((32'(last_idx) + i) % REQ_NUM);
      if (!win_vld && req[w_pos]) begin
        win_vld    = 1'b1;
        win_idx    = w_pos;
        win[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cm_arb_rr_grant.sv
// Round-robin grant stage with IDLE/GRANT/LOCKED ownership tracking.
// Optional CM_ARB_PARK_EN: park gnt/gnt_idx on PARK_IDX while idle (gnt_vld stays 0).
module cm_arb_rr_grant
  import cm_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM   = 2,
  parameter int unsigned PRI_WIDTH = 1,
  parameter int unsigned PARK_IDX  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req,
  input  logic [PRI_WIDTH-1:0]          pri_max,
  input  logic                          adv,
  input  logic                          hold,
  output logic [REQ_NUM-1:0]            gnt,
  output logic [cm_idx_w(REQ_NUM)-1:0]  gnt_idx,
  output logic                          gnt_vld,
  output logic [PRI_WIDTH-1:0]          gnt_pri
);

  localparam int unsigned IDX_W = cm_idx_w(REQ_NUM);

`ifdef CM_ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  localparam logic [REQ_NUM-1:0] IDLE_GNT = PARK_EN ? (REQ_NUM'(1) << PARK_IDX) : '0;
  localparam logic [IDX_W-1:0]   IDLE_IDX = PARK_EN ? IDX_W'(PARK_IDX) : '0;
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(REQ_NUM - 1);

  cm_arb_state_e          r_state;
  logic [REQ_NUM-1:0]     r_gnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_vld;
  logic [PRI_WIDTH-1:0]   r_pri;
  logic [IDX_W-1:0]       r_last;

  logic [REQ_NUM-1:0]     w_win;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_vld;
  logic                   w_arb;

  cm_arb_rr_sel #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req      (req),
    .last_idx (r_last),
    .win      (w_win),
    .win_idx  (w_win_idx),
    .win_vld  (w_win_vld)
  );

  // IDLE always arbitrates; GRANT and LOCKED share the release rule (adv && !hold),
  // so both owner states collapse into one arbitration decision.
  assign w_arb = (r_state == ST_IDLE) || (adv && !hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= IDLE_GNT;
      r_idx   <= IDLE_IDX;
      r_vld   <= 1'b0;
      r_pri   <= '0;
      r_last  <= LAST_RST;
    end else begin
      case (r_state)
        ST_IDLE, ST_GRANT, ST_LOCKED: begin
          if (w_arb) begin
            if (w_win_vld) begin
              r_state <= ST_GRANT;
              r_gnt   <= w_win;
              r_idx   <= w_win_idx;
              r_vld   <= 1'b1;
              r_pri   <= pri_max;
              r_last  <= w_win_idx;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= IDLE_GNT;
              r_idx   <= IDLE_IDX;
              r_vld   <= 1'b0;
              r_pri   <= '0;
            end
          end else if (adv && hold) begin
            r_state <= ST_LOCKED;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= IDLE_GNT;
          r_idx   <= IDLE_IDX;
          r_vld   <= 1'b0;
          r_pri   <= '0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign gnt_pri = r_pri;

endmodule

// File: tb/tb_cm_arb_rr_grant.sv
// Directed bench for cm_arb_rr_grant (REQ_NUM=4, PRI_WIDTH=2, default build).
module tb_cm_arb_rr_grant;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] pri_max;
  logic       adv;
  logic       hold;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [1:0] gnt_pri;

  int n_cmp;
  int n_err;

  cm_arb_rr_grant #(
    .REQ_NUM   (4),
    .PRI_WIDTH (2),
    .PARK_IDX  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pri_max (pri_max),
    .adv     (adv),
    .hold    (hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .gnt_pri (gnt_pri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(ev));
    chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    req     = 4'b0000;
    pri_max = 2'd0;
    adv     = 1'b0;
    hold    = 1'b0;
    #2;
    chk_g("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.pri", 32'(gnt_pri), 32'd0);

    // First grant: lowest requesting index after reset
    step();
    rst = 1'b0; req = 4'b1010; pri_max = 2'd2;
    step();
    chk_g("first", 4'b0010, 2'd1, 1'b1);
    chk("first.pri", 32'(gnt_pri), 32'd2);

    // No adv: grant and priority frozen despite req/pri changes
    req = 4'b0100; pri_max = 2'd3;
    step();
    chk_g("noadv", 4'b0010, 2'd1, 1'b1);
    chk("noadv.pri", 32'(gnt_pri), 32'd2);

    // Rotate 1 -> 3 -> 1 (wrap)
    req = 4'b1010; pri_max = 2'd1; adv = 1'b1;
    step();
    chk_g("rot3", 4'b1000, 2'd3, 1'b1);
    chk("rot3.pri", 32'(gnt_pri), 32'd1);
    step();
    chk_g("wrap1", 4'b0010, 2'd1, 1'b1);

    // Lock owner 1, then hold through competing requests
    hold = 1'b1;
    step();
    chk_g("lock", 4'b0010, 2'd1, 1'b1);
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_g("locked", 4'b0010, 2'd1, 1'b1);
    end
    hold = 1'b0;
    step();
    chk_g("unlock", 4'b1000, 2'd3, 1'b1);

    // Sole requester re-wins
    step();
    chk_g("sole", 4'b1000, 2'd3, 1'b1);

    // Release with no requests -> IDLE
    req = 4'b0000;
    step();
    chk_g("toidle", 4'b0000, 2'd0, 1'b0);

    // IDLE ignores adv/hold
    hold = 1'b1;
    step();
    chk_g("idleign", 4'b0000, 2'd0, 1'b0);

    // last_idx=3 retained: from idle, search starts at 0
    adv = 1'b0; hold = 1'b0; req = 4'b0011; pri_max = 2'd3;
    step();
    chk_g("reidle", 4'b0001, 2'd0, 1'b1);
    chk("reidle.pri", 32'(gnt_pri), 32'd3);

    // Full request rotation 0 -> 1 -> 2 -> 3 -> 0
    req = 4'b1111; adv = 1'b1;
    step();
    chk_g("rr1", 4'b0010, 2'd1, 1'b1);
    step();
    chk_g("rr2", 4'b0100, 2'd2, 1'b1);
    step();
    chk_g("rr3", 4'b1000, 2'd3, 1'b1);
    step();
    chk_g("rr0", 4'b0001, 2'd0, 1'b1);

    // Locked release with no requests -> IDLE
    hold = 1'b1;
    step();
    chk_g("lock2", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000; hold = 1'b0;
    step();
    chk_g("lockidle", 4'b0000, 2'd0, 1'b0);

    // Get into LOCKED again, then async reset mid-cycle
    req = 4'b0100; adv = 1'b0;
    step();
    chk_g("pre", 4'b0100, 2'd2, 1'b1);
    adv = 1'b1; hold = 1'b1;
    step();
    chk_g("prelock", 4'b0100, 2'd2, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_g("asyncrst", 4'b0000, 2'd0, 1'b0);
    chk("asyncrst.pri", 32'(gnt_pri), 32'd0);
    #1;
    rst = 1'b0; req = 4'b0001; adv = 1'b0; hold = 1'b0;
    step();
    chk_g("postrst", 4'b0001, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cm_arb_rr_grant.md
CM_ARB_RR_GRANT -- requirements
Module: cm_arb_rr_grant

Interface
REQ-001 The block SHALL take parameter REQ_NUM, default 2, meaning the number of requesters, legal range 1..16.
REQ-002 The block SHALL take parameter PRI_WIDTH, default 1, meaning the width of the winning-priority field.
REQ-003 The block SHALL take parameter PARK_IDX, default 0, meaning the parking requester index, used only under CM_ARB_PARK_EN.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clk  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst  input  1  is the asynchronous, active-high reset.
REQ-007 Port req  input  REQ_NUM  carries the priority-filtered requests from the upstream priority stage.
REQ-008 Port pri_max  input  PRI_WIDTH  carries the winning priority level from the upstream stage.
REQ-009 Port adv  input  1  is the advance strobe, meaning the current owner's address phase is accepted.
REQ-010 Port hold  input  1  is the owner lock request (locked or burst sequence), sampled only with adv.
REQ-011 Port gnt  output  REQ_NUM  is the registered grant, one-hot or zero.
REQ-012 Port gnt_idx  output  IDX_W  is the binary index of the grant, where IDX_W = max(1, clog2(REQ_NUM)).
REQ-013 Port gnt_vld  output  1  is high when gnt selects a real requester.
REQ-014 Port gnt_pri  output  PRI_WIDTH  is pri_max captured at the moment the grant was issued.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT and LOCKED.
REQ-016 In IDLE with req != 0, the block SHALL issue the round-robin winner on the next edge, move to GRANT and set gnt_vld=1; latency is 1 cycle.
REQ-017 The round-robin search SHALL start at (last_idx+1) mod REQ_NUM, ascend, and wrap past REQ_NUM-1 to 0.
REQ-018 last_idx SHALL update only when a new grant is issued.
REQ-019 In GRANT with adv=0, gnt, gnt_idx and gnt_pri SHALL hold, regardless of req changes.
REQ-020 In GRANT with adv=1 and hold=1, the block SHALL keep the current grant and move to LOCKED.
REQ-021 In GRANT with adv=1, hold=0 and req != 0, the block SHALL re-arbitrate on the same edge; the same owner may win again only if it is the sole requester.
REQ-022 In GRANT with adv=1, hold=0 and req == 0, the block SHALL clear the grant, set gnt_vld=0 and go to IDLE.
REQ-023 In LOCKED, the grant SHALL be frozen; adv=1 with hold=0 SHALL re-arbitrate exactly as in REQ-021 and REQ-022, and any other input SHALL keep LOCKED.
REQ-024 In IDLE, adv and hold SHALL be ignored.
REQ-025 gnt SHALL never have more than one bit set; gnt_idx SHALL equal the index of the set bit, or 0 when gnt is 0.
REQ-026 When REQ_NUM=1, the block SHALL grant bit 0 whenever req[0]=1 under the REQ-016 to REQ-023 state rules.

Reset
REQ-027 On rst=1, the block SHALL immediately and asynchronously set state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, gnt_pri=0 and last_idx=REQ_NUM-1, so that the first winner is the lowest requesting index.
REQ-028 A reset in GRANT or LOCKED SHALL drop the grant in the same cycle with no completion of the pending transfer.

Configuration
REQ-029 Macro CM_ARB_PARK_EN, when defined, SHALL make IDLE and reset drive gnt to one-hot PARK_IDX and gnt_idx to PARK_IDX, with gnt_vld=0 and last_idx unaffected.
REQ-030 When CM_ARB_PARK_EN is undefined, the block SHALL drive gnt=0 in IDLE and PARK_IDX SHALL be unused.

Structure
REQ-031 Package cm_arb_pkg SHALL hold the state encoding constants and the clog2 function shared with the other cm_arb blocks.
REQ-032 Sub-module cm_arb_rr_sel SHALL be a combinational rotate-priority selector: inputs req and last_idx, outputs a one-hot winner and its index.

Verification (REQ_NUM=4, PRI_WIDTH=2)
REQ-033 Reset, then req=1010, pri_max=2 -> next cycle gnt=0010, gnt_idx=1, gnt_vld=1, gnt_pri=2.
REQ-034 From REQ-033, hold req=1010 and pulse adv with hold=0 -> gnt=1000; pulse adv again -> gnt=0010 (wrap).
REQ-035 With owner idx1, adv with hold=1 and then req=1000 with adv and hold=1 for 3 cycles -> gnt stays 0010; adv with hold=0 -> gnt=1000.
REQ-036 In GRANT, adv=1 with req=0000 -> gnt=0000, gnt_vld=0, state IDLE; with CM_ARB_PARK_EN and PARK_IDX=2 -> gnt=0100, gnt_vld=0.
REQ-037 Assert rst mid-cycle while LOCKED -> gnt, gnt_vld and gnt_pri clear before the next edge; after release, req=0001 -> gnt=0001.
